// File: rtl/mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg: shared state encoding, decode and owner constants for the bus arbiter
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] RAM_REGION = 2'b11;
  localparam logic       OWNER_CPU  = 1'b0;
  localparam logic       OWNER_DMA  = 1'b1;

  function automatic logic is_ram(input logic [1:0] top_bits);
    return (top_bits == RAM_REGION);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2: two-input round-robin grant with the registered owner bit
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter2
  import mem_bus_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_cpu,
  input  logic req_dma,
  input  logic grant_en,
  output logic grant_valid,
  output logic grant_id,
  output logic owner
);

  logic r_owner;

  // On a tie the port that did not own the bus last time wins.
  always_comb begin
    grant_valid = req_cpu | req_dma;
    grant_id    = OWNER_CPU;
    if (req_cpu && req_dma)
      grant_id = ~r_owner;
    else if (req_dma)
      grant_id = OWNER_DMA;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_owner <= OWNER_DMA;
    else if (grant_en && grant_valid)
      r_owner <= grant_id;
  end

  assign owner = r_owner;

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter: CPU/DMA sharing of the ROM+RAM bus with decode and strobe sequencing
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              dma_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_data_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              ram_sel,
  output logic              rom_sel,
  output logic              owner,
  output logic              busy
);

  localparam logic [2:0] c_WAIT_LAST = 3'(WAIT_STATES);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_cnt;
  logic [2:0]        w_cnt_nxt;
  logic              r_wr;
  logic              w_grant_valid;
  logic              w_grant_id;
  logic              w_grant_en;
  logic              w_last;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  logic              w_win_wr;
  logic              w_done_nxt;

  assign w_grant_en = (r_state == IDLE);

  rr_arbiter2 u_rr (
    .clk         (clk),
    .reset       (reset),
    .req_cpu     (cpu_req),
    .req_dma     (dma_req),
    .grant_en    (w_grant_en),
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id),
    .owner       (owner)
  );

  assign w_win_addr  = (w_grant_id == OWNER_DMA) ? dma_addr  : cpu_addr;
  assign w_win_wdata = (w_grant_id == OWNER_DMA) ? dma_wdata : cpu_wdata;
  assign w_win_wr    = (w_grant_id == OWNER_DMA) ? dma_wr    : cpu_wr;
  assign w_last      = (r_cnt == c_WAIT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_grant_valid)
          w_state_nxt = SETUP;
      end
      SETUP: begin
        w_state_nxt = ACCESS;
        w_cnt_nxt   = 3'd0;
      end
      ACCESS: begin
        if (w_last)
          w_state_nxt = DONE;
        else if (r_cnt != 3'd7)
          w_cnt_nxt = r_cnt + 3'd1;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Transfer attributes latched at grant; sel and addr then hold until the next grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ram_sel   <= 1'b0;
      rom_sel   <= 1'b0;
    end else if (w_grant_en && w_grant_valid) begin
      r_wr      <= w_win_wr;
      mem_addr  <= w_win_addr;
      mem_wdata <= w_win_wdata;
      ram_sel   <= is_ram(w_win_addr[ADDR_W-1 -: 2]);
      rom_sel   <= !is_ram(w_win_addr[ADDR_W-1 -: 2]);
    end
  end

  assign w_done_nxt = (w_state_nxt == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      dma_ack <= 1'b0;
      dma_err <= 1'b0;
    end else begin
      mem_rd  <= (w_state_nxt == ACCESS) && !r_wr;
      mem_wr  <= (w_state_nxt == ACCESS) && r_wr && ram_sel;
      cpu_ack <= w_done_nxt && (owner == OWNER_CPU);
      cpu_err <= w_done_nxt && (owner == OWNER_CPU) && r_wr && rom_sel;
      dma_ack <= w_done_nxt && (owner == OWNER_DMA);
      dma_err <= w_done_nxt && (owner == OWNER_DMA) && r_wr && rom_sel;
    end
  end

  // Only the owner's read register is touched, on the final ACCESS edge of a read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else if ((r_state == ACCESS) && w_last && !r_wr) begin
      if (owner == OWNER_CPU)
        cpu_rdata <= mem_rdata;
      else
        dma_rdata <= mem_rdata;
    end
  end

  assign busy        = (r_state != IDLE);
  assign mem_data_oe = ((r_state == SETUP) || (r_state == ACCESS)) && r_wr && ram_sel;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter: directed self-checking bench with a behavioural ROM/RAM
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack, cpu_err;
  logic        dma_req = 1'b0, dma_wr = 1'b0;
  logic [12:0] dma_addr = '0;
  logic [7:0]  dma_wdata = '0;
  logic [7:0]  dma_rdata;
  logic        dma_ack, dma_err;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_data_oe, mem_rd, mem_wr, ram_sel, rom_sel, owner, busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] rom [0:8191];
  logic [7:0] ram [0:2047];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(13), .DATA_W(8), .WAIT_STATES(1)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack), .dma_err(dma_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_data_oe(mem_data_oe),
    .mem_rdata(mem_rdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ram_sel(ram_sel), .rom_sel(rom_sel), .owner(owner), .busy(busy)
  );

  assign mem_rdata = !mem_rd ? 8'h00 : (ram_sel ? ram[mem_addr[10:0]] : rom[mem_addr]);

  always @(posedge clk) begin
    if (mem_wr && ram_sel)
      ram[mem_addr[10:0]] <= mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int max, output int n, output logic c, output logic d);
    n = 0;
    c = 1'b0;
    d = 1'b0;
    while (n < max) begin
      tick();
      n++;
      if (cpu_ack || dma_ack) begin
        c = cpu_ack;
        d = dma_ack;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic c, d;
    logic saw_wr, saw_oe;

    for (int i = 0; i < 8192; i++) rom[i] = 8'(i) ^ 8'h5A;
    rom[4]  = 8'hA5;
    rom[16] = 8'h42;

    // Reset values
    tick();
    tick();
    chk("rst_busy",    busy, 0);
    chk("rst_owner",   owner, 1);
    chk("rst_strobes", {mem_rd, mem_wr, mem_data_oe, ram_sel, rom_sel}, 0);
    chk("rst_acks",    {cpu_ack, cpu_err, dma_ack, dma_err}, 0);
    chk("rst_addr",    {mem_addr, mem_wdata}, 0);
    chk("rst_rdata",   {cpu_rdata, dma_rdata}, 0);
    reset = 1'b1;
    tick();

    // CPU read of ROM[4]
    cpu_wr = 1'b0; cpu_addr = 13'h0004; cpu_req = 1'b1;
    tick();
    chk("rd_setup_busy", busy, 1);
    chk("rd_setup_sel",  {rom_sel, ram_sel}, 2'b10);
    chk("rd_setup_addr", mem_addr, 13'h0004);
    chk("rd_setup_rd",   mem_rd, 0);
    chk("rd_owner",      owner, 0);
    tick();
    chk("rd_acc1_rd", mem_rd, 1);
    tick();
    chk("rd_acc2_rd",  mem_rd, 1);
    chk("rd_acc2_ack", cpu_ack, 0);
    tick();
    chk("rd_done_ack",   {cpu_ack, cpu_err, dma_ack}, 3'b100);
    chk("rd_done_rdata", cpu_rdata, 8'hA5);
    chk("rd_done_rd",    mem_rd, 0);
    cpu_req = 1'b0;
    tick();
    chk("rd_idle", {cpu_ack, busy}, 0);

    // DMA write of RAM 0x1802
    dma_wr = 1'b1; dma_addr = 13'h1802; dma_wdata = 8'h3C; dma_req = 1'b1;
    tick();
    chk("wr_setup_sel", {ram_sel, rom_sel, owner}, 3'b101);
    chk("wr_setup_oe",  {mem_data_oe, mem_wr}, 2'b10);
    tick();
    chk("wr_acc1", {mem_data_oe, mem_wr, mem_wdata}, {2'b11, 8'h3C});
    tick();
    chk("wr_acc2", {mem_data_oe, mem_wr}, 2'b11);
    tick();
    chk("wr_done", {dma_ack, dma_err, cpu_ack, mem_wr, mem_data_oe}, 5'b10000);
    dma_req = 1'b0;
    chk("wr_ram_content", ram[2], 8'h3C);
    tick();

    // CPU read-back of RAM 0x1802
    cpu_wr = 1'b0; cpu_addr = 13'h1802; cpu_req = 1'b1;
    wait_ack(10, n, c, d);
    chk("rb_latency",   n, 4);
    chk("rb_ack",       {c, d}, 2'b10);
    chk("rb_rdata",     cpu_rdata, 8'h3C);
    chk("rb_dma_rdata", dma_rdata, 8'h00);
    cpu_req = 1'b0;
    tick();

    // CPU write to ROM 0x0010 must not strobe the bus
    cpu_wr = 1'b1; cpu_addr = 13'h0010; cpu_wdata = 8'hFF; cpu_req = 1'b1;
    saw_wr = 1'b0; saw_oe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      saw_wr |= mem_wr;
      saw_oe |= mem_data_oe;
    end
    chk("romwr_ack_err", {cpu_ack, cpu_err, rom_sel}, 3'b111);
    chk("romwr_no_wr",   {saw_wr, saw_oe}, 2'b00);
    chk("romwr_content", rom[16], 8'h42);
    cpu_req = 1'b0; cpu_wr = 1'b0;
    tick();
    chk("romwr_err_pulse", {cpu_ack, cpu_err}, 2'b00);

    // Reset during the first ACCESS cycle of a RAM write
    dma_wr = 1'b1; dma_addr = 13'h1805; dma_wdata = 8'h11; dma_req = 1'b1;
    tick();
    tick();
    chk("abort_pre_wr", mem_wr, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_strobes", {mem_wr, mem_rd, mem_data_oe, busy}, 0);
    chk("abort_acks",    {dma_ack, dma_err, cpu_ack}, 0);
    chk("abort_owner",   owner, 1);
    dma_req = 1'b0; dma_wr = 1'b0;
    tick();

    // Both ports requesting from reset release: CPU, DMA, CPU, DMA
    reset = 1'b1;
    cpu_addr = 13'h0004; dma_addr = 13'h1802;
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(10, n, c, d);
      chk("rr_latency", n, 4);
      chk("rr_cpu_ack", c, (k % 2) == 0);
      chk("rr_dma_ack", d, (k % 2) == 1);
      if ((k % 2) == 0) chk("rr_cpu_rdata", cpu_rdata, 8'hA5);
      else              chk("rr_dma_rdata", dma_rdata, 8'h3C);
      if (k == 3) begin
        cpu_req = 1'b0;
        dma_req = 1'b0;
      end
      tick();
      chk("rr_ack_pulse", {cpu_ack, dma_ack}, 2'b00);
    end

    // Seed RAM[0] through the DMA port
    dma_wr = 1'b1; dma_addr = 13'h1800; dma_wdata = 8'h77; dma_req = 1'b1;
    wait_ack(10, n, c, d);
    chk("seed_ack", {c, d}, 2'b01);
    dma_req = 1'b0; dma_wr = 1'b0;
    tick();

    // DMA read request held for one cycle only
    dma_req = 1'b1;
    tick();
    dma_req = 1'b0;
    wait_ack(10, n, c, d);
    chk("drop_latency",   n, 3);
    chk("drop_ack",       {c, d}, 2'b01);
    chk("drop_rdata",     dma_rdata, 8'h77);
    chk("drop_cpu_rdata", cpu_rdata, 8'hA5);
    tick();
    chk("drop_ack_once", {dma_ack, busy}, 2'b00);
    tick();
    chk("drop_no_rereq", {dma_ack, busy}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 13-bit address / 8-bit data memory bus (ROM + RAM) between two requesters: the CPU and a DMA/loader port used for program and data download.
- Performs round-robin arbitration, address decode and the rd/wr strobe sequencing for each access.
- Returns read data and a one-cycle ack to the owning requester.
- Sits between the cpu/loader and the rom/ram instances, and replaces the stand-alone address decode at top level.

Parameters:
- ADDR_W, 13, address width of requesters and memory bus.
- DATA_W, 8, data width.
- WAIT_STATES, 1, extra ACCESS cycles beyond the first (0..7).

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, level, held until cpu_ack.
- cpu_wr  in  1  1 = write, 0 = read; stable while cpu_req.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  registered read data, valid with cpu_ack, held until next CPU read completes.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_err  out  1  pulses with cpu_ack when a write targeted ROM.
- dma_req, dma_wr, dma_addr, dma_wdata, dma_rdata, dma_ack, dma_err: same as the cpu_* ports, for the DMA port.
- mem_addr  out  ADDR_W  bus address.
- mem_wdata  out  DATA_W  bus write data.
- mem_data_oe  out  1  top level drives the tri-state data bus from mem_wdata when 1.
- mem_rdata  in  DATA_W  bus read data.
- mem_rd  out  1  read strobe.
- mem_wr  out  1  write strobe.
- ram_sel  out  1  RAM select.
- rom_sel  out  1  ROM select.
- owner  out  1  0 = CPU, 1 = DMA; the current or last grant.
- busy  out  1  1 in any state except IDLE.

Behaviour:
- Reset:
  - All outputs are 0; owner = 1, so the CPU wins the first tie.
  - State = IDLE; mem_addr and mem_wdata = 0.
  - Reset during a transfer aborts it immediately: strobes drop asynchronously and no ack is issued.
- Decode:
  - ram_sel = (addr[12:11] == 2'b11).
  - rom_sel = !ram_sel.
  - Decode is registered in SETUP.
- FSM states: IDLE, SETUP, ACCESS, DONE.
  - IDLE:
    - With no request, stay in IDLE.
    - With one request, grant it.
    - With both requests, grant the port != owner (round-robin).
    - On grant: latch the winner's addr, wdata and wr; set owner; go to SETUP.
  - SETUP (1 cycle):
    - mem_addr and sel are valid.
    - mem_data_oe = 1 for a RAM write.
    - No strobes.
  - ACCESS (WAIT_STATES+1 cycles, via an internal counter):
    - mem_rd = 1 for reads.
    - mem_wr = 1 for RAM writes; mem_wr stays 0 for ROM writes.
    - mem_rdata is captured into the owner's rdata register on the last ACCESS edge.
  - DONE (1 cycle):
    - Owner's ack = 1; err = 1 if the access was a ROM write.
    - Strobes = 0; sel and addr are held.
    - Next state is IDLE.
- Latency: a request sampled at edge k causes ack to be high in the cycle following edge k+2+WAIT_STATES. WAIT_STATES=1 gives 4 cycles from sample to ack. Throughput is 1 access per 4+WAIT_STATES cycles.
- Strobe timing: mem_rd and mem_wr are registered outputs. They never overlap, and never assert in SETUP or DONE.
- Request deassertion: deasserting req mid-transfer does not abort the transfer; the ack still pulses. The request is not re-sampled until IDLE.
- Request held past ack: a requester that keeps req high after ack is treated as a new request in the next IDLE, and round-robin applies.
- Read data: the non-owner rdata register is never modified.
- Counter: 3 bits; it saturates, so there is no wrap hazard for WAIT_STATES ≤ 7.

Decomposition:
- Shared package mem_bus_pkg holds:
  - state encoding constants (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, DONE=2'd3);
  - decode constant RAM_REGION = 2'b11;
  - OWNER_CPU = 1'b0 and OWNER_DMA = 1'b1.
- One sub-module, rr_arbiter2: a combinational two-input round-robin grant plus the registered owner bit.
- Everything else (FSM, decode, data capture) lives in mem_bus_arbiter.

Test Plan:
- CPU read ROM: cpu_req=1, cpu_wr=0, cpu_addr=13'h0004, ROM[4]=8'hA5, WAIT_STATES=1 → rom_sel=1, mem_rd high for 2 cycles, cpu_ack high in cycle 4 after sample, cpu_rdata=8'hA5, cpu_err=0.
- DMA write RAM: dma_addr=13'h1802, dma_wdata=8'h3C → ram_sel=1, mem_data_oe=1 in SETUP/ACCESS, mem_wr 2 cycles, dma_ack pulse; subsequent CPU read of 13'h1802 returns 8'h3C.
- Simultaneous requests: cpu_req and dma_req held high from reset → grant order CPU, DMA, CPU, DMA (owner toggles), each ack 1 cycle, never both acks together.
- ROM write: cpu_wr=1, cpu_addr=13'h0010 → mem_wr stays 0 throughout, cpu_ack=1 and cpu_err=1 in the same cycle, ROM[16] unchanged.
- Reset mid-ACCESS: assert reset low during the first ACCESS cycle of a RAM write → mem_wr, busy and ack drop to 0 immediately; after release owner=1, and the next tie goes to CPU.
- Req dropped early: dma_req pulsed for 1 cycle with dma_addr=13'h1800 (read) → full transfer still runs, dma_ack pulses once, dma_rdata = RAM[0].
